// File: rtl/seg_scan_capture.sv
// seg_scan_capture: passive monitor for a multiplexed, active-low 7-segment bus.
// It synchronizes SEG/DIGIT and waits for each digit slot to hold steady for
// SETTLE_CYCLES cycles. It then decodes the segment pattern back to a hex
// nibble and publishes a full 8-slot frame once every slot has been seen.
// Optional feature macro: SEG_SCAN_DP_EN. It captures and publishes the decimal
// points. When it is left undefined, SEG bit7 is ignored and DP_MASK reads 0.
module seg_scan_capture #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  SEG,
    input  logic [7:0]  DIGIT,
    output logic [31:0] DIGITS,
    output logic [7:0]  ERR_MASK,
    output logic [7:0]  DP_MASK,
    output logic        FRAME_VALID
);

`ifdef SEG_SCAN_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int KEY_W = SEG_W + 8;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SETTLE_MAX  = 16'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Active-high gfedcba pattern to {error, nibble}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg_on);
        logic [4:0] res;
        case (seg_on)
            7'h3F:   res = 5'h00;
            7'h06:   res = 5'h01;
            7'h5B:   res = 5'h02;
            7'h4F:   res = 5'h03;
            7'h66:   res = 5'h04;
            7'h6D:   res = 5'h05;
            7'h7D:   res = 5'h06;
            7'h07:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h6F:   res = 5'h09;
            7'h77:   res = 5'h0A;
            7'h7C:   res = 5'h0B;
            7'h39:   res = 5'h0C;
            7'h5E:   res = 5'h0D;
            7'h79:   res = 5'h0E;
            7'h71:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    // True when exactly one anode select is driven low.
    function automatic logic digit_valid(input logic [7:0] dig);
        logic res;
        case (dig)
            8'hFE, 8'hFD, 8'hFB, 8'hF7,
            8'hEF, 8'hDF, 8'hBF, 8'h7F: res = 1'b1;
            default:                    res = 1'b0;
        endcase
        return res;
    endfunction

    // Slot number selected by a valid active-low anode pattern.
    function automatic logic [2:0] slot_index(input logic [7:0] dig);
        logic [2:0] res;
        case (dig)
            8'hFE:   res = 3'd0;
            8'hFD:   res = 3'd1;
            8'hFB:   res = 3'd2;
            8'hF7:   res = 3'd3;
            8'hEF:   res = 3'd4;
            8'hDF:   res = 3'd5;
            8'hBF:   res = 3'd6;
            8'h7F:   res = 3'd7;
            default: res = 3'd0;
        endcase
        return res;
    endfunction

    logic [SEG_W-1:0] seg_s1_r, seg_s2_r;
    logic [7:0]       dig_s1_r, dig_s2_r;
    logic [KEY_W-1:0] key_s, key_prev_r;
    logic             changed_s, valid_s;
    logic [15:0]      cnt_r;
    state_t           state_r, state_nxt_s;
    logic             cap_en_s, cnt_clr_s;
    logic [2:0]       cap_slot_s;
    logic [4:0]       cap_dec_s;
    logic [7:0]       slot_bit_s;
    logic [31:0]      work_nib_r;
    logic [7:0]       work_err_r, seen_r;
    logic             pub_pend_r;

    assign key_s      = {seg_s2_r, dig_s2_r};
    assign changed_s  = (key_s != key_prev_r);
    assign valid_s    = digit_valid(dig_s2_r);
    // key_prev_r holds the value that was just proven stable, so capture from it.
    assign cap_slot_s = slot_index(key_prev_r[7:0]);
    assign cap_dec_s  = seg_decode(~key_prev_r[14:8]);
    assign slot_bit_s = 8'h01 << cap_slot_s;

    // Two-stage input synchronizer plus the previous-cycle copy used for change detection.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            seg_s1_r   <= {SEG_W{1'b1}};
            seg_s2_r   <= {SEG_W{1'b1}};
            dig_s1_r   <= 8'hFF;
            dig_s2_r   <= 8'hFF;
            key_prev_r <= {KEY_W{1'b1}};
        end else begin
            seg_s1_r   <= SEG[SEG_W-1:0];
            seg_s2_r   <= seg_s1_r;
            dig_s1_r   <= DIGIT;
            dig_s2_r   <= dig_s1_r;
            key_prev_r <= key_s;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_s) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    state_nxt_s = valid_s ? ST_SETTLE : ST_IDLE;
                end else if (cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            // A change seen during the capture cycle must not be lost to HOLD.
            ST_CAPTURE, ST_HOLD: begin
                if (changed_s) begin
                    state_nxt_s = valid_s ? ST_SETTLE : ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: slot write strobe and settle-counter control.
    always_comb begin
        cap_en_s  = 1'b0;
        cnt_clr_s = 1'b1;
        case (state_r)
            ST_SETTLE: begin
                cnt_clr_s = changed_s;
            end
            ST_CAPTURE: begin
                cap_en_s  = 1'b1;
            end
            default: begin
                cap_en_s  = 1'b0;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Settle counter: restarts on any change and saturates at SETTLE_CYCLES.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_r <= 16'h0000;
        end else if (cnt_clr_s) begin
            cnt_r <= 16'h0000;
        end else if (cnt_r != SETTLE_MAX) begin
            cnt_r <= cnt_r + 16'h0001;
        end
    end

    // Working frame: slot write, seen tracking, and the frame-complete flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            work_nib_r <= 32'h0000_0000;
            work_err_r <= 8'h00;
            seen_r     <= 8'h00;
            pub_pend_r <= 1'b0;
        end else begin
            pub_pend_r <= 1'b0;
            if (pub_pend_r) begin
                seen_r <= 8'h00;
            end
            if (cap_en_s) begin
                work_nib_r[{cap_slot_s, 2'b00} +: 4] <= cap_dec_s[3:0];
                work_err_r[cap_slot_s]               <= cap_dec_s[4];
                seen_r                               <= seen_r | slot_bit_s;
                pub_pend_r                           <= ((seen_r | slot_bit_s) == 8'hFF);
            end
        end
    end

    // Published frame: copied from the working registers one cycle after completion.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            DIGITS      <= 32'h0000_0000;
            ERR_MASK    <= 8'h00;
            FRAME_VALID <= 1'b0;
        end else begin
            FRAME_VALID <= pub_pend_r;
            if (pub_pend_r) begin
                DIGITS   <= work_nib_r;
                ERR_MASK <= work_err_r;
            end
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [7:0] work_dp_r, dp_out_r;

    // Decimal-point working bits and their published copy.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            work_dp_r <= 8'h00;
            dp_out_r  <= 8'h00;
        end else begin
            if (cap_en_s) begin
                work_dp_r[cap_slot_s] <= ~key_prev_r[15];
            end
            if (pub_pend_r) begin
                dp_out_r <= work_dp_r;
            end
        end
    end

    assign DP_MASK = dp_out_r;
`else
    assign DP_MASK = 8'h00;
`endif

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Passive monitor for the multiplexed 7-segment bus on the Nexys4 DDR. It samples the active-low SEG/DIGIT lines that the display scanner drives and waits for each digit slot to settle. It then decodes each segment pattern back to a hex nibble and, once all eight slots have been seen, emits one frame of 8 nibbles with per-slot error flags. It is used for on-board loopback self-check and for simulation scoreboarding of display logic.

## Interface
- SETTLE_CYCLES, 16: consecutive stable cycles of synchronized SEG/DIGIT required before capture; legal range 1..65535.
- CLK  input  1  system clock (100 MHz); all logic on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- SEG  input  8  segment lines, active-low; bit0=a … bit6=g, bit7=dp.
- DIGIT  input  8  anode selects, active-low; bit n low = slot n.
- DIGITS  output  32  captured frame; slot n at [4n+3:4n]; reset 0.
- ERR_MASK  output  8  bit n = slot n pattern not in decode table; reset 0.
- DP_MASK  output  8  bit n = dp lit in slot n; reset 0.
- FRAME_VALID  output  1  one-cycle pulse when DIGITS/ERR_MASK/DP_MASK update; reset 0.

## Operation
- Input stage: SEG and DIGIT pass through two flop stages (s1, s2). All decisions use s2.
- DIGIT s2 is "valid" only if exactly one bit is 0. All-ones, all-zeros, and multi-low patterns are invalid.
- FSM states:
  - IDLE: wait for valid DIGIT → SETTLE, counter cleared.
  - SETTLE: counter increments each cycle while s2 {SEG,DIGIT} equals the previous cycle's value. Any change restarts the counter (stays in SETTLE if still valid, else → IDLE). When counter reaches SETTLE_CYCLES → CAPTURE.
  - CAPTURE (1 cycle): write slot; → HOLD.
  - HOLD: wait for any change of s2 {SEG,DIGIT}. Valid → SETTLE, invalid → IDLE.
- Decode of ~SEG[6:0] (gfedcba), active-high values: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Unmatched pattern (including blank 00): slot nibble = 0 and slot error bit = 1.
- Working registers: 8 nibbles, 8 err bits, 8 dp bits, 8-bit seen mask. A capture overwrites slot n and sets seen[n]. A re-capture of the same slot before the frame completes overwrites it.
- Frame complete: seen == 8'hFF after a write.
  - The next cycle copies working registers to the outputs, pulses FRAME_VALID, and clears seen.
  - Working nibbles are retained, not cleared.
- Outputs are stable between FRAME_VALID pulses.

## Timing
- Pin change to slot write: 2 (sync) + SETTLE_CYCLES + 1 cycles.
- Final slot write to FRAME_VALID and output update: 1 cycle.
- At most one capture per SETTLE_CYCLES+1 cycles, so a frame publish never collides with a second capture.
- The counter saturates at SETTLE_CYCLES and never wraps.
- Reset mid-frame or mid-settle: all state, including seen, clears the same cycle. The first FRAME_VALID after reset requires all 8 slots to be captured afresh.
- Both input flop stages also reset to 8'hFF (all inactive).

## Configuration
- SEG_SCAN_DP_EN defined: bit7 is captured into the dp working bits, and DP_MASK publishes with the frame. Bit7 still takes part in stability comparison.
- Not defined: bit7 is ignored entirely, including for stability comparison. DP_MASK is tied to 0, and the dp registers are not built.

## Test plan
- SETTLE_CYCLES=4; drive slots 0..7 with hex 1,2,3,4,5,6,7,8 (each held 10 cycles) → one FRAME_VALID, DIGITS=32'h87654321, ERR_MASK=0.
- Hold slot 3 with SEG=~8'h00 (blank) in an otherwise valid scan → DIGITS[15:12]=0, ERR_MASK=8'h08.
- Toggle SEG on slot 2 every 3 cycles for 40 cycles, then hold 2 → no capture during toggling; slot 2 captured 7 cycles after the final stable value at the pins.
- DIGIT=8'hF0 or 8'hFF for 20 cycles → no capture, seen unchanged, no FRAME_VALID.
- Capture slots 0..4, assert RST_N=0 for 1 cycle, then a full scan of 9s → exactly one FRAME_VALID, DIGITS=32'h99999999, and no earlier pulse.
- With SEG_SCAN_DP_EN, dp lit on slots 0 and 7 → DP_MASK=8'h81; without the macro → DP_MASK=0 and the decoded digits are unchanged.
